uart_rx_cfg: RTL and testbench

Configurable UART receiver: the parametrised successor to the existing fixed-format receiver on the host-to-RLE-core link. Data width, parity mode and stop-bit count are configurable. It reports parity and framing errors, and presents each received word through a valid/ready holding register with overrun detection. It sits between the board RX pin and the RLE input logic, so the downstream consumer can stall without losing the current word silently.

---
 rtl/uart_rx_cfg.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
//==============================================================================
// Module : uart_rx_cfg
// Configurable UART receiver (width/parity/stop bits) with valid/ready holding
// register, parity/framing error flags and overrun detection.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 435,
    parameter int DATA_BITS    = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 din,
    output logic [DATA_BITS-1:0] dout,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_BIT_W = 5;
    localparam int c_IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [c_CNT_W-1:0] c_HALF      = c_CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [c_CNT_W-1:0] c_LAST      = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BIT_W-1:0] c_LAST_DATA = c_BIT_W'(DATA_BITS - 1);
    localparam logic [c_BIT_W-1:0] c_LAST_STOP = c_BIT_W'(STOP_BITS - 1);
    localparam bit                 c_HAS_PAR   = (PARITY != 0);
    localparam bit                 c_ODD       = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_PAR     = 3'd3,
        S_STOP    = 3'd4,
        S_WAIT_HI = 3'd5
    } state_t;

    state_t                 r_state;
    logic                   r_sync1;
    logic                   r_sync2;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_BIT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par_acc;
    logic                   r_perr_int;
    logic                   r_ferr_int;

    logic [DATA_BITS-1:0]   r_dout;
    logic                   r_valid;
    logic                   r_parity_err;
    logic                   r_frame_err;
    logic                   r_overrun;

    logic                   w_line;
    logic                   w_tick;
    logic                   w_done;
    logic                   w_frame_err;

    assign w_line      = r_sync2;
    assign w_tick      = (r_cnt == c_LAST);
    assign w_done      = (r_state == S_STOP) && w_tick && (r_bit_cnt == c_LAST_STOP);
    assign w_frame_err = r_ferr_int | ~w_line;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_acc  <= 1'b0;
            r_perr_int <= 1'b0;
            r_ferr_int <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt     <= '0;
                    r_bit_cnt <= '0;
                    if (!w_line) begin
                        r_state    <= S_START;
                        r_par_acc  <= 1'b0;
                        r_perr_int <= 1'b0;
                        r_ferr_int <= 1'b0;
                    end
                end
                S_START: begin
                    // Re-check the line at mid start bit to reject short glitches
                    if (r_cnt == c_HALF) begin
                        r_cnt   <= '0;
                        r_state <= w_line ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_cnt                            <= '0;
                        r_shift[r_bit_cnt[c_IDX_W-1:0]]  <= w_line;
                        r_par_acc                        <= r_par_acc ^ w_line;
                        if (r_bit_cnt == c_LAST_DATA) begin
                            r_bit_cnt <= '0;
                            r_state   <= c_HAS_PAR ? S_PAR : S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_PAR: begin
                    if (w_tick) begin
                        r_cnt      <= '0;
                        r_bit_cnt  <= '0;
                        r_perr_int <= c_ODD ? ~(r_par_acc ^ w_line) : (r_par_acc ^ w_line);
                        r_state    <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        r_cnt      <= '0;
                        r_ferr_int <= w_frame_err;
                        if (r_bit_cnt == c_LAST_STOP) begin
                            r_bit_cnt <= '0;
                            // A held-low line (break) must return high before a new start
                            r_state   <= (w_frame_err && !w_line) ? S_WAIT_HI : S_IDLE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_HI: begin
                    r_cnt <= '0;
                    if (w_line) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout       <= '0;
            r_valid      <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else if (w_done) begin
            if (!r_valid || ready) begin
                r_dout       <= r_shift;
                r_parity_err <= r_perr_int;
                r_frame_err  <= w_frame_err;
                r_valid      <= 1'b1;
                r_overrun    <= 1'b0;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && ready) begin
            r_valid      <= 1'b0;
            r_overrun    <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end
    end

    assign dout       = r_dout;
    assign valid      = r_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
//==============================================================================
// Module : tb_uart_rx_cfg
// Directed self-checking bench for uart_rx_cfg (8E1 @16 clk/bit, 16N1 @20 clk/bit).
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_uart_rx_cfg;

    localparam int NA = 16;
    localparam int NB = 20;

    logic        clk;
    logic        rst_n;
    logic        din_a, din_b;
    logic        ready_a, ready_b;
    logic [7:0]  dout_a;
    logic [15:0] dout_b;
    logic        valid_a, valid_b;
    logic        perr_a, perr_b;
    logic        ferr_a, ferr_b;
    logic        ovr_a, ovr_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int          rise_a = 0, rise_cyc_a = 0, fall_cyc_a = 0;
    logic        pv_a = 1'b0;
    logic [7:0]  cap_dout_a = '0;
    logic [2:0]  cap_flg_a  = '0;

    int          rise_b = 0, rise_cyc_b = 0;
    logic        pv_b = 1'b0;
    logic [15:0] cap_dout_b [0:63];
    logic [2:0]  cap_flg_b  [0:63];

    uart_rx_cfg #(.CLKS_PER_BIT(NA), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .din(din_a), .dout(dout_a), .valid(valid_a),
        .ready(ready_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a)
    );

    uart_rx_cfg #(.CLKS_PER_BIT(NB), .DATA_BITS(16), .PARITY(0), .STOP_BITS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(din_b), .dout(dout_b), .valid(valid_b),
        .ready(ready_b), .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every rising edge of valid together with the word and flags it presented
    always @(negedge clk) begin
        if (valid_a && !pv_a) begin
            rise_a++;
            rise_cyc_a = cyc;
            cap_dout_a = dout_a;
            cap_flg_a  = {ovr_a, perr_a, ferr_a};
        end
        if (!valid_a && pv_a) fall_cyc_a = cyc;
        pv_a = valid_a;
        if (valid_b && !pv_b) begin
            if (rise_b < 64) begin
                cap_dout_b[rise_b] = dout_b;
                cap_flg_b[rise_b]  = {ovr_b, perr_b, ferr_b};
            end
            rise_b++;
            rise_cyc_b = cyc;
        end
        pv_b = valid_b;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input bit sel, input logic b, input int n);
        if (sel) din_b = b;
        else     din_a = b;
        repeat (n) @(negedge clk);
    endtask

    // par < 0 means no parity bit; e1 is the first edge that sees the start bit
    task automatic send_frame(input bit sel, input logic [15:0] data, input int nbits,
                              input int par, input logic stop, output int e1);
        int n;
        n  = sel ? NB : NA;
        e1 = cyc + 1;
        drive_bit(sel, 1'b0, n);
        for (int i = 0; i < nbits; i++) drive_bit(sel, data[i], n);
        if (par >= 0) drive_bit(sel, par[0], n);
        drive_bit(sel, stop, n);
    endtask

    initial begin
        int e1, eb, r0;
        rst_n = 1'b0; din_a = 1'b1; din_b = 1'b1; ready_a = 1'b0; ready_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid_a", 32'(valid_a), 32'h0);
        check("rst_dout_a",  32'(dout_a),  32'h0);
        check("rst_perr_a",  32'(perr_a),  32'h0);
        check("rst_ferr_a",  32'(ferr_a),  32'h0);
        check("rst_ovr_a",   32'(ovr_a),   32'h0);
        check("rst_valid_b", 32'(valid_b), 32'h0);
        check("rst_dout_b",  32'(dout_b),  32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Good 8E1 frame, consumer always ready
        ready_a = 1'b1; r0 = rise_a;
        send_frame(1'b0, 16'h00A5, 8, 0, 1'b1, e1);
        repeat (NA) @(negedge clk);
        check("a1_count",   32'(rise_a - r0),           32'd1);
        check("a1_latency", 32'(rise_cyc_a - e1),       32'd170);
        check("a1_dout",    32'(cap_dout_a),            32'hA5);
        check("a1_flags",   32'(cap_flg_a),             32'h0);
        check("a1_fall",    32'(fall_cyc_a - rise_cyc_a), 32'd1);
        check("a1_valid",   32'(valid_a),               32'h0);

        // Wrong parity bit
        r0 = rise_a;
        send_frame(1'b0, 16'h00A5, 8, 1, 1'b1, e1);
        repeat (NA) @(negedge clk);
        check("a2_count", 32'(rise_a - r0), 32'd1);
        check("a2_dout",  32'(cap_dout_a),  32'hA5);
        check("a2_flags", 32'(cap_flg_a),   32'h2);

        // Low stop bit followed by a break
        r0 = rise_a;
        send_frame(1'b0, 16'h003C, 8, 0, 1'b0, e1);
        drive_bit(1'b0, 1'b0, 40);
        drive_bit(1'b0, 1'b1, 30 * NA);
        check("a3_count", 32'(rise_a - r0), 32'd1);
        check("a3_dout",  32'(cap_dout_a),  32'h3C);
        check("a3_flags", 32'(cap_flg_a),   32'h1);
        check("a3_valid", 32'(valid_a),     32'h0);

        // 5-cycle glitch, then a real frame held in the register
        ready_a = 1'b0; r0 = rise_a;
        drive_bit(1'b0, 1'b0, 5);
        drive_bit(1'b0, 1'b1, 3 * NA);
        check("a4_glitch_count", 32'(rise_a - r0), 32'd0);
        check("a4_glitch_valid", 32'(valid_a),     32'h0);
        send_frame(1'b0, 16'h0055, 8, 0, 1'b1, e1);
        repeat (NA) @(negedge clk);
        check("a4_valid",   32'(valid_a),         32'h1);
        check("a4_dout",    32'(dout_a),          32'h55);
        check("a4_flags",   32'({ovr_a, perr_a, ferr_a}), 32'h0);
        check("a4_latency", 32'(rise_cyc_a - e1), 32'd170);

        // 16N1: overrun while consumer stalls
        send_frame(1'b1, 16'h1234, 16, -1, 1'b1, e1);
        repeat (NB) @(negedge clk);
        check("b1_valid",   32'(valid_b),         32'h1);
        check("b1_dout",    32'(dout_b),          32'h1234);
        check("b1_flags",   32'({ovr_b, perr_b, ferr_b}), 32'h0);
        check("b1_latency", 32'(rise_cyc_b - e1), 32'd352);
        send_frame(1'b1, 16'hBEEF, 16, -1, 1'b1, e1);
        repeat (NB) @(negedge clk);
        check("b1_hold_valid", 32'(valid_b), 32'h1);
        check("b1_hold_dout",  32'(dout_b),  32'h1234);
        check("b1_overrun",    32'(ovr_b),   32'h1);

        ready_b = 1'b1;
        @(negedge clk);
        check("b2_valid", 32'(valid_b), 32'h0);
        check("b2_ovr",   32'(ovr_b),   32'h0);
        check("b2_dout",  32'(dout_b),  32'h1234);
        ready_b = 1'b0;

        send_frame(1'b1, 16'h0F0F, 16, -1, 1'b1, e1);
        repeat (NB) @(negedge clk);
        check("b3_valid", 32'(valid_b), 32'h1);
        check("b3_dout",  32'(dout_b),  32'h0F0F);
        check("b3_ovr",   32'(ovr_b),   32'h0);

        // Handshake lands on the completion edge: replace without a gap
        eb = cyc + 1;
        fork
            send_frame(1'b1, 16'hC3A5, 16, -1, 1'b1, e1);
            begin
                while (cyc < eb + 351) @(negedge clk);
                check("b4_pre_valid", 32'(valid_b), 32'h1);
                check("b4_pre_dout",  32'(dout_b),  32'h0F0F);
                ready_b = 1'b1;
                @(negedge clk);
                check("b4_valid", 32'(valid_b), 32'h1);
                check("b4_dout",  32'(dout_b),  32'hC3A5);
                check("b4_ovr",   32'(ovr_b),   32'h0);
                ready_b = 1'b0;
            end
        join
        check("b4_hold_dout", 32'(dout_b), 32'hC3A5);

        // Back-to-back frames with no idle gap
        ready_b = 1'b1;
        @(negedge clk);
        check("b5_drain", 32'(valid_b), 32'h0);
        r0 = rise_b;
        send_frame(1'b1, 16'h0001, 16, -1, 1'b1, e1);
        send_frame(1'b1, 16'hFFFF, 16, -1, 1'b1, e1);
        send_frame(1'b1, 16'h8000, 16, -1, 1'b1, e1);
        repeat (3 * NB) @(negedge clk);
        check("b5_count", 32'(rise_b - r0), 32'd3);
        check("b5_w0", 32'(cap_dout_b[r0]),     32'h0001);
        check("b5_w1", 32'(cap_dout_b[r0 + 1]), 32'hFFFF);
        check("b5_w2", 32'(cap_dout_b[r0 + 2]), 32'h8000);
        check("b5_flags", 32'({cap_flg_b[r0], cap_flg_b[r0 + 1], cap_flg_b[r0 + 2]}), 32'h0);

        // Load both receivers with state, then reset mid-frame
        ready_b = 1'b0;
        send_frame(1'b1, 16'h5A5A, 16, -1, 1'b1, e1);
        send_frame(1'b1, 16'h1111, 16, -1, 1'b1, e1);
        repeat (NB) @(negedge clk);
        check("r_pre_ovr_b", 32'(ovr_b), 32'h1);
        drive_bit(1'b0, 1'b0, NA);
        drive_bit(1'b0, 1'b0, NA);
        drive_bit(1'b0, 1'b1, NA);
        drive_bit(1'b0, 1'b1, 8);
        r0 = rise_a;
        #2 rst_n = 1'b0;
        #1;
        check("r_valid_a", 32'(valid_a), 32'h0);
        check("r_dout_a",  32'(dout_a),  32'h0);
        check("r_flags_a", 32'({ovr_a, perr_a, ferr_a}), 32'h0);
        check("r_valid_b", 32'(valid_b), 32'h0);
        check("r_dout_b",  32'(dout_b),  32'h0);
        check("r_ovr_b",   32'(ovr_b),   32'h0);
        repeat (2) @(negedge clk);
        check("r_hold_valid_a", 32'(valid_a), 32'h0);
        din_a = 1'b1;
        rst_n = 1'b1;
        repeat (12 * NA) @(negedge clk);
        check("r_no_partial", 32'(rise_a - r0), 32'd0);
        send_frame(1'b0, 16'h007E, 8, 0, 1'b1, e1);
        repeat (NA) @(negedge clk);
        check("r_post_valid",   32'(valid_a),         32'h1);
        check("r_post_dout",    32'(dout_a),          32'h7E);
        check("r_post_flags",   32'({ovr_a, perr_a, ferr_a}), 32'h0);
        check("r_post_latency", 32'(rise_cyc_a - e1), 32'd170);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
